// File: rtl/dds_pkg.sv
// Constants and sweep state encoding shared by the dds sweep sequencer and the dds core.
// The phase width here must match the dds phase-accumulator control input.
package dds_pkg;

  localparam int DDS_W_PHASE = 26;
  localparam int DDS_W_DWELL = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sweep_state_t;

endpackage

// File: rtl/dds_dwell_timer.sv
// Loadable dwell down-counter; load takes a dwell count (0 behaves as 1).
// expire is high in the last cycle of the dwell, i.e. when the count sits at zero.
module dds_dwell_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expire
);

  logic [W-1:0] cnt;

  // Count D-1 down to 0 so the loaded word stays visible for exactly D cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= (value == '0) ? '0 : value - W'(1);
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expire = (cnt == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear frequency-sweep sequencer driving the dds phase-accumulator control word.
// First word appears two edges after i_start; no backpressure, config is shadowed at start.
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int W_PHASE = DDS_W_PHASE,
  parameter int W_DWELL = DDS_W_DWELL
) (
  input  logic               i_sys_clk,
  input  logic               i_sys_rst,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cont,
  input  logic [W_PHASE-1:0] i_f_start,
  input  logic [W_PHASE-1:0] i_f_stop,
  input  logic [W_PHASE-1:0] i_f_step,
  input  logic [W_DWELL-1:0] i_dwell,
  output logic [W_PHASE-1:0] o_dds_phase_accumulator_word,
  output logic               o_step_stb,
  output logic               o_busy,
  output logic               o_done
);

  sweep_state_t       state;
  logic               arm;
  logic [W_PHASE-1:0] word;
  logic               stb;
  logic               busy;
  logic               done;

  logic [W_PHASE-1:0] s_start;
  logic [W_PHASE-1:0] s_stop;
  logic [W_PHASE-1:0] s_step;
  logic [W_DWELL-1:0] s_dwell;
  logic               s_cont;
  logic               s_up;

  logic               expire;
  logic               load;
  logic               at_end;
  logic [W_PHASE:0]   sum;
  logic [W_PHASE-1:0] gap;
  logic [W_PHASE-1:0] next_word;

  assign load = ((state == IDLE) && arm) || ((state == RUN) && expire && !i_stop);

  dds_dwell_timer #(
    .W(W_DWELL)
  ) u_dwell (
    .clk   (i_sys_clk),
    .rst   (i_sys_rst),
    .load  (load),
    .value (s_dwell),
    .expire(expire)
  );

  // A zero step can never reach f_stop, so the start word is treated as the last one.
  assign at_end = (word == s_stop) || (s_step == '0);
  assign sum    = {1'b0, word} + {1'b0, s_step};
  assign gap    = word - s_stop;

  always_comb begin
    next_word = s_stop;
    if (s_up) begin
      if (sum < {1'b0, s_stop}) next_word = sum[W_PHASE-1:0];
    end else begin
      if (s_step < gap) next_word = word - s_step;
    end
  end

  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state   <= IDLE;
      arm     <= 1'b0;
      word    <= '0;
      stb     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      s_start <= '0;
      s_stop  <= '0;
      s_step  <= '0;
      s_dwell <= '0;
      s_cont  <= 1'b0;
      s_up    <= 1'b1;
    end else begin
      stb  <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            arm   <= 1'b0;
            word  <= s_start;
            stb   <= 1'b1;
            busy  <= 1'b1;
            state <= RUN;
          end else if (i_start && !i_stop) begin
            arm     <= 1'b1;
            s_start <= i_f_start;
            s_stop  <= i_f_stop;
            s_step  <= i_f_step;
            s_dwell <= i_dwell;
            s_cont  <= i_cont;
            s_up    <= (i_f_stop >= i_f_start);
          end
        end
        RUN: begin
          // Abort wins over dwell expiry; the current word is left on the dds.
          if (i_stop) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (expire) begin
            if (at_end) begin
              done <= 1'b1;
              if (s_cont) begin
                word <= s_start;
                stb  <= 1'b1;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              word <= next_word;
              stb  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_dds_phase_accumulator_word = word;
  assign o_step_stb                   = stb;
  assign o_busy                       = busy;
  assign o_done                       = done;

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: a word-list sweep model checked every cycle, plus literal pins.
module tb_dds_sweep_ctrl;
  localparam int W  = 26;
  localparam int WD = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          cont = 1'b0;
  logic [W-1:0]  f_start = '0;
  logic [W-1:0]  f_stop = '0;
  logic [W-1:0]  f_step = '0;
  logic [WD-1:0] dwell = '0;
  logic [W-1:0]  word;
  logic          stb;
  logic          busy;
  logic          done;

  always #5 clk = ~clk;

  dds_sweep_ctrl dut (
    .i_sys_clk                   (clk),
    .i_sys_rst                   (rst),
    .i_start                     (start),
    .i_stop                      (stop),
    .i_cont                      (cont),
    .i_f_start                   (f_start),
    .i_f_stop                    (f_stop),
    .i_f_step                    (f_step),
    .i_dwell                     (dwell),
    .o_dds_phase_accumulator_word(word),
    .o_step_stb                  (stb),
    .o_busy                      (busy),
    .o_done                      (done)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Sweep model: the list of words one sweep visits, each held m_d cycles,
  // indexed by cycles elapsed since the first word appeared.
  bit           m_active = 1'b0;
  logic [W-1:0] m_hold = '0;
  int           m_t0 = 0;
  int           m_abort = -1;
  int           m_d = 1;
  int           m_p = 1;
  bit           m_cont = 1'b0;
  int           seq[$];
  int           done_t = -1;
  int           done_cnt = 0;
  int           stb_cnt = 0;

  function automatic logic [W-1:0] word_of(int t);
    if (t < 0) return m_hold;
    if (!m_cont && t >= m_p) return W'(seq[seq.size()-1]);
    return W'(seq[(t % m_p) / m_d]);
  endfunction

  function automatic void expect_at(input int e, output logic [W-1:0] w,
                                    output logic s, output logic b, output logic d);
    int t;
    w = m_hold; s = 1'b0; b = 1'b0; d = 1'b0;
    if (!m_active) return;
    t = e - m_t0;
    if (m_abort >= 0 && e >= m_abort) begin
      w = word_of(m_abort - 1 - m_t0);
      return;
    end
    if (t < 0) return;
    w = word_of(t);
    b = m_cont || (t < m_p);
    s = b && (t % m_d == 0);
    d = (t > 0) && (t % m_p == 0) && (m_cont || t == m_p);
  endfunction

  always @(negedge clk) begin : cmp
    logic [W-1:0] ew;
    logic es, eb, ed;
    expect_at(cyc, ew, es, eb, ed);
    n_cmp++;
    if (word !== ew || stb !== es || busy !== eb || done !== ed) begin
      n_bad++;
      $display("FAIL cycle%0d outputs: got word=%0d stb=%b busy=%b done=%b, want word=%0d stb=%b busy=%b done=%b",
               cyc, word, stb, busy, done, ew, es, eb, ed);
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (done_t < 0) done_t = cyc - m_t0;
    end
    if (stb === 1'b1) stb_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic chk_seq(input string name, input int n, input int e0, input int e1,
                         input int e2, input int e3);
    int ex[4];
    ex = '{e0, e1, e2, e3};
    chk({name, "_len"}, seq.size(), n);
    for (int i = 0; i < n && i < seq.size(); i++) chk($sformatf("%s_w%0d", name, i), seq[i], ex[i]);
  endtask

  task automatic go(input int a, input int b, input int st, input int dw, input bit c);
    logic [W-1:0] w;
    logic s, bb, d;
    int ww;
    @(negedge clk); #1;
    f_start = W'(a); f_stop = W'(b); f_step = W'(st); dwell = WD'(dw); cont = c; start = 1'b1;
    expect_at(cyc, w, s, bb, d);
    m_hold = w;
    seq.delete();
    ww = a;
    seq.push_back(ww);
    while (ww != b && st != 0) begin
      if (b >= a) ww = (ww + st >= b) ? b : ww + st;
      else        ww = (st >= ww - b) ? b : ww - st;
      seq.push_back(ww);
    end
    m_d = (dw == 0) ? 1 : dw;
    m_p = seq.size() * m_d;
    m_cont = c; m_t0 = cyc + 2; m_abort = -1; m_active = 1'b1;
    done_t = -1; done_cnt = 0; stb_cnt = 0;
    @(negedge clk); #1;
    start = 1'b0;
    f_start = W'($urandom); f_stop = W'($urandom); f_step = W'($urandom);
    dwell = WD'($urandom_range(0, 5)); cont = ~c;
  endtask

  task automatic abort_now();
    @(negedge clk); #1;
    stop = 1'b1;
    m_abort = cyc + 1;
    @(negedge clk); #1;
    stop = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_word", int'(word), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_stb", int'(stb), 0);
    chk("rst_done", int'(done), 0);
    rst = 1'b0;

    go(100, 400, 100, 3, 1'b0);
    chk_seq("up_seq", 4, 100, 200, 300, 400);
    repeat (15) @(negedge clk);
    #1;
    chk("up_word_end", int'(word), 400);
    chk("up_busy_end", int'(busy), 0);
    chk("up_done_t", done_t, 12);
    chk("up_stb_cnt", stb_cnt, 4);
    chk("up_done_cnt", done_cnt, 1);

    go(100, 400, 120, 2, 1'b0);
    chk_seq("clamp_seq", 4, 100, 220, 340, 400);
    repeat (10) @(negedge clk);
    #1;
    chk("clamp_word_end", int'(word), 400);
    chk("clamp_stb_cnt", stb_cnt, 4);

    go(6711, 6700, 5, 0, 1'b0);
    chk_seq("down_seq", 4, 6711, 6706, 6701, 6700);
    repeat (7) @(negedge clk);
    #1;
    chk("down_word_end", int'(word), 6700);
    chk("down_done_t", done_t, 4);

    go(10, 30, 10, 2, 1'b1);
    chk_seq("cont_seq", 3, 10, 20, 30, 0);
    repeat (8) @(negedge clk);
    #1;
    start = 1'b1;
    f_start = W'(999); f_stop = W'(5);
    @(negedge clk); #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    abort_now();
    repeat (3) @(negedge clk);
    #1;
    chk("cont_done_cnt", done_cnt, 2);
    chk("cont_abort_word", int'(word), 30);
    chk("cont_abort_busy", int'(busy), 0);

    go(100, 400, 100, 3, 1'b0);
    repeat (6) @(negedge clk);
    #1;
    stop = 1'b1;
    m_abort = cyc + 1;
    @(negedge clk); #1;
    stop = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("abort_word", int'(word), 200);
    chk("abort_done_cnt", done_cnt, 0);

    @(negedge clk); #1;
    start = 1'b1; stop = 1'b1;
    @(negedge clk); #1;
    start = 1'b0; stop = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("startstop_busy", int'(busy), 0);
    chk("startstop_word", int'(word), 200);

    go(50, 90, 0, 2, 1'b0);
    chk_seq("step0_seq", 1, 50, 0, 0, 0);
    repeat (4) @(negedge clk);
    #1;
    chk("step0_done_cnt", done_cnt, 1);
    chk("step0_word", int'(word), 50);

    go(77, 77, 5, 1, 1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("eq_cont_done_cnt", done_cnt, 4);
    abort_now();
    repeat (2) @(negedge clk);

    go(100, 400, 100, 3, 1'b0);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    m_active = 1'b0;
    m_hold = '0;
    #1;
    chk("midrst_word", int'(word), 0);
    chk("midrst_busy", int'(busy), 0);
    @(negedge clk); #1;
    rst = 1'b0;
    go(100, 400, 100, 3, 1'b0);
    repeat (15) @(negedge clk);
    #1;
    chk("restart_word", int'(word), 400);
    chk("restart_done_t", done_t, 12);

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
